// File: rtl/bg_pkg.sv
// Shared colours, flash state encoding and default frame geometry for the
// background scene generator.
package bg_pkg;

  localparam int COORD_W = 11;

  localparam logic [7:0] COL_EDGE    = 8'b000_111_11;
  localparam logic [7:0] COL_BRACKET = 8'hFF;
  localparam logic [7:0] COL_SEA     = 8'b000_010_11;
  localparam logic [7:0] COL_FOAM    = 8'b011_111_11;
  localparam logic [7:0] COL_BG      = 8'h00;

  localparam int DEF_X_FRAME     = 635;
  localparam int DEF_Y_FRAME     = 475;
  localparam int DEF_BRACKET_OFS = 30;
  localparam int DEF_SEA_TOP_Y   = 445;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FLASH_ON  = 2'd1,
    FLASH_OFF = 2'd2
  } flash_state_t;

  function automatic logic [7:0] flash_color(input logic [7:0] c, input logic inv);
    return inv ? ~c : c;
  endfunction

endpackage

// File: rtl/bg_scene_gen_if.sv
// Pixel-side bus between the VGA timing/game logic and the background generator.
interface bg_scene_gen_if;
  import bg_pkg::*;

  logic               startOfFrame;
  logic [COORD_W-1:0] pixelX;
  logic [COORD_W-1:0] pixelY;
  logic               seaRise;
  logic               seaClr;
  logic               flashReq;
  logic [7:0]         BG_RGB;
  logic               boardersDR;
  logic               seaDR;
  logic               flashBusy;

  modport master (
    output startOfFrame, pixelX, pixelY, seaRise, seaClr, flashReq,
    input  BG_RGB, boardersDR, seaDR, flashBusy
  );

  modport slave (
    input  startOfFrame, pixelX, pixelY, seaRise, seaClr, flashReq,
    output BG_RGB, boardersDR, seaDR, flashBusy
  );
endinterface

// File: rtl/bg_frame_timer.sv
// Frame divider driving the wave phase: phase advances once every
// FRAMES_PER_STEP frames and wraps modulo WAVE_PERIOD.
module bg_frame_timer #(
  parameter  int FRAMES_PER_STEP = 4,
  parameter  int WAVE_PERIOD     = 16,
  localparam int PH_W            = $clog2(WAVE_PERIOD)
) (
  input  logic            clk,
  input  logic            resetN,
  input  logic            startOfFrame,
  output logic [PH_W-1:0] phase
);

  localparam int FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  logic [FC_W-1:0] frame_cnt;

  // WAVE_PERIOD is a power of 2, so the natural wrap of phase is the modulo.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt <= '0;
      phase     <= '0;
    end else if (startOfFrame) begin
      if (frame_cnt == FC_W'(FRAMES_PER_STEP - 1)) begin
        frame_cnt <= '0;
        phase     <= phase + 1'b1;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bg_scene_gen.sv
// Background generator: frame, bracket lines, rising sea with scrolling crest,
// and a frame-counted colour-inversion flash. Outputs are registered.
module bg_scene_gen
  import bg_pkg::*;
#(
  parameter int X_FRAME         = DEF_X_FRAME,
  parameter int Y_FRAME         = DEF_Y_FRAME,
  parameter int BRACKET_OFS     = DEF_BRACKET_OFS,
  parameter int SEA_TOP_Y       = DEF_SEA_TOP_Y,
  parameter int SEA_STEP        = 8,
  parameter int SEA_MAX_STEPS   = 4,
  parameter int WAVE_PERIOD     = 16,
  parameter int FRAMES_PER_STEP = 4,
  parameter int FLASH_HALF      = 8,
  parameter int FLASH_TOGGLES   = 6
) (
  input logic           clk,
  input logic           resetN,
  bg_scene_gen_if.slave bus
);

  localparam int PH_W   = $clog2(WAVE_PERIOD);
  localparam int RISE_W = (SEA_MAX_STEPS > 0) ? $clog2(SEA_MAX_STEPS + 1) : 1;
  localparam int HALF_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
  localparam int TOG_W  = (FLASH_TOGGLES > 0) ? $clog2(FLASH_TOGGLES + 1) : 1;

  if (SEA_TOP_Y - SEA_MAX_STEPS * SEA_STEP < 3) begin : g_bad_sea
    $error("bg_scene_gen: SEA_TOP_Y - SEA_MAX_STEPS*SEA_STEP must be >= 3");
  end
  if (WAVE_PERIOD < 4 || (WAVE_PERIOD & (WAVE_PERIOD - 1)) != 0) begin : g_bad_wave
    $error("bg_scene_gen: WAVE_PERIOD must be a power of 2 and >= 4");
  end

  function automatic logic [RISE_W-1:0] rise_sat_inc(input logic [RISE_W-1:0] r);
    return (r == RISE_W'(SEA_MAX_STEPS)) ? r : r + 1'b1;
  endfunction

  logic [PH_W-1:0]    phase;
  logic [RISE_W-1:0]  rise;
  logic               rise_pend, clr_pend, flash_pend;
  flash_state_t       state, state_d;
  logic [HALF_W-1:0]  half_cnt, half_cnt_d;
  logic [TOG_W-1:0]   tog_cnt, tog_cnt_d;

  bg_frame_timer #(
    .FRAMES_PER_STEP(FRAMES_PER_STEP),
    .WAVE_PERIOD    (WAVE_PERIOD)
  ) u_timer (
    .clk         (clk),
    .resetN      (resetN),
    .startOfFrame(bus.startOfFrame),
    .phase       (phase)
  );

  // Pulses landing on the startOfFrame cycle are folded in directly so they
  // take effect at that same edge.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rise      <= '0;
      rise_pend <= 1'b0;
      clr_pend  <= 1'b0;
    end else if (bus.startOfFrame) begin
      if (clr_pend || bus.seaClr)
        rise <= '0;
      else if (rise_pend || bus.seaRise)
        rise <= rise_sat_inc(rise);
      rise_pend <= 1'b0;
      clr_pend  <= 1'b0;
    end else begin
      rise_pend <= rise_pend | bus.seaRise;
      clr_pend  <= clr_pend | bus.seaClr;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      half_cnt   <= '0;
      tog_cnt    <= '0;
      flash_pend <= 1'b0;
    end else begin
      state    <= state_d;
      half_cnt <= half_cnt_d;
      tog_cnt  <= tog_cnt_d;
      if (bus.startOfFrame)
        flash_pend <= 1'b0;
      else
        flash_pend <= flash_pend | (bus.flashReq && state == IDLE);
    end
  end

  always_comb begin
    state_d    = state;
    half_cnt_d = half_cnt;
    tog_cnt_d  = tog_cnt;
    if (bus.startOfFrame) begin
      case (state)
        IDLE: begin
          if (flash_pend || bus.flashReq) begin
            state_d    = FLASH_ON;
            half_cnt_d = '0;
            tog_cnt_d  = '0;
          end
        end
        FLASH_ON, FLASH_OFF: begin
          if (half_cnt == HALF_W'(FLASH_HALF - 1)) begin
            half_cnt_d = '0;
            tog_cnt_d  = tog_cnt + 1'b1;
            if (tog_cnt == TOG_W'(FLASH_TOGGLES - 1))
              state_d = IDLE;
            else
              state_d = (state == FLASH_ON) ? FLASH_OFF : FLASH_ON;
          end else begin
            half_cnt_d = half_cnt + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ---- stage p0: classify the current pixel against the pre-update state ----
  logic [COORD_W-1:0] sea_top;
  logic [PH_W-1:0]    wave_pos;
  logic               crest_p0, on_edge_p0, on_bracket_p0;
  logic [7:0]         col_p0;
  logic               bdr_p0, sea_p0;

  assign sea_top  = COORD_W'(SEA_TOP_Y) - COORD_W'(rise) * COORD_W'(SEA_STEP);
  assign wave_pos = bus.pixelX[PH_W-1:0] + phase;
  assign crest_p0 = (wave_pos < PH_W'(WAVE_PERIOD / 2));

  assign on_edge_p0 = (bus.pixelX == '0) || (bus.pixelX == COORD_W'(X_FRAME)) ||
                      (bus.pixelY == '0) || (bus.pixelY == COORD_W'(Y_FRAME));
  assign on_bracket_p0 = (bus.pixelX == COORD_W'(BRACKET_OFS)) ||
                         (bus.pixelX == COORD_W'(X_FRAME - BRACKET_OFS)) ||
                         (bus.pixelY == COORD_W'(BRACKET_OFS)) ||
                         (bus.pixelY == COORD_W'(Y_FRAME - BRACKET_OFS));

  always_comb begin
    col_p0 = COL_BG;
    bdr_p0 = 1'b0;
    sea_p0 = 1'b0;
    if (on_edge_p0) begin
      col_p0 = COL_EDGE;
    end else if (on_bracket_p0) begin
      col_p0 = COL_BRACKET;
      bdr_p0 = 1'b1;
    end else if (bus.pixelY >= sea_top) begin
      col_p0 = COL_SEA;
      sea_p0 = 1'b1;
    end else if (crest_p0 && (bus.pixelY == sea_top - 1'b1 ||
                              bus.pixelY == sea_top - 2'd2)) begin
      col_p0 = COL_FOAM;
      sea_p0 = 1'b1;
    end
  end

  // ---- stage p1: registered outputs ----
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bus.BG_RGB     <= '0;
      bus.boardersDR <= 1'b0;
      bus.seaDR      <= 1'b0;
      bus.flashBusy  <= 1'b0;
    end else begin
      bus.BG_RGB     <= flash_color(col_p0, state == FLASH_ON);
      bus.boardersDR <= bdr_p0;
      bus.seaDR      <= sea_p0;
      bus.flashBusy  <= (state_d != IDLE);
    end
  end

endmodule
